muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and sizing helpers.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between register bank, mul/div unit and write-back.
// The abort signal exists only when MUL_DIV_ABORT_EN is defined.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             hi_we;
   logic             lo_we;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MUL_DIV_ABORT_EN
   logic             abort;

   modport master (output start, op, A, B, hi_we, lo_we, abort,
                   input  busy, done, hi, lo);
   modport slave  (input  start, op, A, B, hi_we, lo_we, abort,
                   output busy, done, hi, lo);
`else
   modport master (output start, op, A, B, hi_we, lo_we,
                   input  busy, done, hi, lo);
   modport slave  (input  start, op, A, B, hi_we, lo_we,
                   output busy, done, hi, lo);
`endif

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on a {upper, lower} 2*WIDTH accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_operand,
   input  logic               i_is_div,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;

   always_comb begin
      w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
      w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
      w_diff   = w_rem_sh - {1'b0, i_operand};
      if (i_is_div) begin
         // MSB of the (WIDTH+1)-bit difference is the borrow: restore on borrow
         if (!w_diff[WIDTH])
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
         else
            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else if (i_acc[0]) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and start/busy/done handshake.
// Define MUL_DIV_ABORT_EN to enable the abort input.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic     clk,
   input  logic     R,
   muldiv_if.slave  bus
);

   localparam int CW = cnt_w(WIDTH);

   state_t             r_state, w_state;
   logic [CW-1:0]      r_cnt, w_cnt;
   logic [2*WIDTH-1:0] r_acc, w_acc;
   logic [WIDTH-1:0]   r_opd, w_opd;
   logic               r_is_div, w_is_div;
   logic               r_neg, w_neg;
   logic               r_sa, w_sa;
   logic [WIDTH-1:0]   r_hi, w_hi;
   logic [WIDTH-1:0]   r_lo, w_lo;
   logic               r_done, w_done;

   logic [2*WIDTH-1:0] w_step;
   logic               w_signed_op;
   logic               w_div_op;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_acc     (r_acc),
      .i_operand (r_opd),
      .i_is_div  (r_is_div),
      .o_acc     (w_step)
   );

   assign w_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign w_div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign w_abs_a     = (w_signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign w_abs_b     = (w_signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_acc    = r_acc;
      w_opd    = r_opd;
      w_is_div = r_is_div;
      w_neg    = r_neg;
      w_sa     = r_sa;
      w_hi     = r_hi;
      w_lo     = r_lo;
      w_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state  = CALC;
               w_cnt    = '0;
               w_is_div = w_div_op;
               w_sa     = w_signed_op && bus.A[WIDTH-1];
               w_neg    = w_signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               // Multiply walks the multiplier in the low half; divide shifts the dividend out of it
               w_acc    = w_div_op ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
               w_opd    = w_div_op ? w_abs_b : w_abs_a;
            end else begin
               if (bus.hi_we) w_hi = bus.A;
               if (bus.lo_we) w_lo = bus.A;
            end
         end
         CALC: begin
            w_acc = w_step;
            w_cnt = r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) w_state = FIX;
         end
         FIX: begin
            w_state = IDLE;
            w_done  = 1'b1;
            if (r_is_div) begin
               w_lo = (r_opd == '0) ? '1 :
                      (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
               w_hi = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end else begin
               {w_hi, w_lo} = r_neg ? -r_acc : r_acc;
            end
         end
         default: w_state = IDLE;
      endcase
`ifdef MUL_DIV_ABORT_EN
      if (r_state != IDLE && bus.abort) begin
         w_state = IDLE;
         w_hi    = r_hi;
         w_lo    = r_lo;
         w_done  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_is_div <= 1'b0;
         r_neg    <= 1'b0;
         r_sa     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_acc    <= w_acc;
         r_opd    <= w_opd;
         r_is_div <= w_is_div;
         r_neg    <= w_neg;
         r_sa     <= w_sa;
         r_hi     <= w_hi;
         r_lo     <= w_lo;
         r_done   <= w_done;
      end
   end

   assign bus.busy = (r_state != IDLE);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule
